// File: rtl/lsu_pkg.sv
// lsu_pkg: shared memory op codes, RISC-V funct3 values, mcause codes and FSM states for the LSU
package lsu_pkg;

    // Memory port op_code is {write, size}; the word store is 111 so 110 is never driven.
    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_NOP = 3'b011;
    localparam logic [2:0] MEM_SB  = 3'b100;
    localparam logic [2:0] MEM_SH  = 3'b101;
    localparam logic [2:0] MEM_SW  = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/lsu_if.sv
// lsu_if: bundle of the LSU's EX request, data-memory port, writeback and exception signals
//   master: the LSU side (accepts EX requests, drives memory, produces writeback/exceptions)
//   slave : the surrounding core/memory side
interface lsu_if #(
    parameter int AW   = 14,
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_store;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_base;
    logic [XLEN-1:0] ex_offset;
    logic [XLEN-1:0] ex_wdata;
    logic [4:0]      ex_rd;
    logic [2:0]      op_code;
    logic [AW-1:0]   rwaddr;
    logic [XLEN-1:0] wdata;
    logic            stall;
    logic [XLEN-1:0] rdata;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            store_done;
    logic            exc_valid;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_tval;

    modport master (
        input  ex_valid, ex_store, ex_funct3, ex_base, ex_offset, ex_wdata, ex_rd, rdata, wb_ready,
        output ex_ready, op_code, rwaddr, wdata, stall, wb_valid, wb_rd, wb_data,
               store_done, exc_valid, exc_cause, exc_tval
    );

    modport slave (
        output ex_valid, ex_store, ex_funct3, ex_base, ex_offset, ex_wdata, ex_rd, rdata, wb_ready,
        input  ex_ready, op_code, rwaddr, wdata, stall, wb_valid, wb_rd, wb_data,
               store_done, exc_valid, exc_cause, exc_tval
    );
endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: funct3-driven sign/zero extension of right-justified memory read data
//   funct3: load kind (LB/LH/LW/LBU/LHU)
//   rdata : raw memory read data, zero-filled above the accessed size
//   data  : extended load result
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);
    always_comb
        data = funct3 == F3_LB  ? {{(XLEN-8){rdata[7]}}, rdata[7:0]} :
               funct3 == F3_LH  ? {{(XLEN-16){rdata[15]}}, rdata[15:0]} :
               funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, rdata[7:0]} :
               funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, rdata[15:0]} :
               rdata;
endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit between EX and data memory with address checks and writeback handshake
//   clk : core clock
//   nrst: synchronous active-high reset
//   bus : lsu_if.master carrying EX request, memory port, writeback and exception outputs
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int AW   = 14,
    parameter int XLEN = 32
) (
    input  logic  clk,
    input  logic  nrst,
    lsu_if.master bus
);
    logic [1:0]      state;
    logic [2:0]      op_q;
    logic [2:0]      f3_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] wd_q;
    logic [4:0]      rd_q;
    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            store_done_q;
    logic            exc_valid_q;
    logic [3:0]      exc_cause_q;
    logic [XLEN-1:0] exc_tval_q;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] ext;
    logic [XLEN-1:0] wd_masked;
    logic [2:0]      mem_op;
    logic [3:0]      cause;
    logic            illegal;
    logic            misaligned;
    logic            out_range;
    logic            fail;
    logic            accept;

    lsu_load_ext #(.XLEN(XLEN)) u_ext (
        .funct3(f3_q),
        .rdata (bus.rdata),
        .data  (ext)
    );

    // Checks are prioritised illegal > misaligned > out of range; later ones only matter if earlier pass.
    always_comb begin
        addr       = bus.ex_base + bus.ex_offset;
        illegal    = bus.ex_store ? bus.ex_funct3 > F3_SW
                                  : bus.ex_funct3[1:0] == 2'b11 || bus.ex_funct3 == 3'b110;
        misaligned = (bus.ex_funct3[1:0] == 2'b01 && addr[0]) ||
                     (bus.ex_funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        out_range  = |addr[XLEN-1:AW];
        fail       = illegal || misaligned || out_range;
        cause      = illegal    ? CAUSE_ILLEGAL :
                     misaligned ? (bus.ex_store ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED) :
                                  (bus.ex_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT);
        mem_op     = !bus.ex_store                  ? {1'b0, bus.ex_funct3[1:0]} :
                     bus.ex_funct3[1:0] == 2'b10    ? MEM_SW :
                                                      {1'b1, bus.ex_funct3[1:0]};
        wd_masked  = bus.ex_funct3[1:0] == 2'b00 ? XLEN'(bus.ex_wdata[7:0]) :
                     bus.ex_funct3[1:0] == 2'b01 ? XLEN'(bus.ex_wdata[15:0]) :
                                                   bus.ex_wdata;
    end

    // A held, unaccepted result blocks new requests so it cannot be overwritten.
    assign bus.ex_ready   = state == ST_IDLE && !(wb_valid_q && !bus.wb_ready);
    assign accept         = bus.ex_valid && bus.ex_ready;
    assign bus.op_code    = state == ST_ACCESS ? op_q : MEM_NOP;
    assign bus.stall      = state != ST_ACCESS;
    assign bus.rwaddr     = addr_q;
    assign bus.wdata      = wd_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.store_done = store_done_q;
    assign bus.exc_valid  = exc_valid_q;
    assign bus.exc_cause  = exc_cause_q;
    assign bus.exc_tval   = exc_tval_q;

    always_ff @(posedge clk) begin
        if (nrst) begin
            state        <= ST_IDLE;
            op_q         <= MEM_NOP;
            f3_q         <= '0;
            addr_q       <= '0;
            wd_q         <= '0;
            rd_q         <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            store_done_q <= 1'b0;
            exc_valid_q  <= 1'b0;
            exc_cause_q  <= '0;
            exc_tval_q   <= '0;
        end else begin
            exc_valid_q  <= accept && fail;
            store_done_q <= state == ST_ACCESS && op_q[2];
            if (accept && fail) begin
                exc_cause_q <= cause;
                exc_tval_q  <= addr;
            end
            if (state == ST_RESP) begin
                wb_valid_q <= 1'b1;
                wb_data_q  <= ext;
                wb_rd_q    <= rd_q;
            end else if (wb_valid_q && bus.wb_ready) begin
                wb_valid_q <= 1'b0;
            end
            if (state == ST_IDLE && accept && !fail) begin
                op_q   <= mem_op;
                f3_q   <= bus.ex_funct3;
                addr_q <= addr[AW-1:0];
                wd_q   <= wd_masked;
                rd_q   <= bus.ex_rd;
                state  <= ST_ACCESS;
            end else if (state == ST_ACCESS) begin
                state <= op_q[2] ? ST_IDLE : ST_RESP;
            end else if (state == ST_RESP) begin
                state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: scoreboard bench for lsu_stage with a byte-array memory and a reference load/store model
module tb_lsu_stage;
    import lsu_pkg::*;

    localparam int AW   = 14;
    localparam int MEMN = 1 << AW;

    typedef struct {
        int          kind;
        logic [3:0]  cause;
        logic [31:0] val;
        logic [4:0]  rd;
    } ev_t;

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
    } mop_t;

    localparam int K_EXC   = 0;
    localparam int K_STORE = 1;
    localparam int K_LOAD  = 2;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    bit   rand_ready = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ev_t  evq[$];
    mop_t memq[$];
    logic [7:0] ref_mem [MEMN];
    logic [7:0] mem [MEMN];

    always #5 clk = ~clk;

    lsu_if #(.AW(AW), .XLEN(32)) bus ();

    lsu_stage #(.AW(AW), .XLEN(32)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // Reference: expected exception, memory op and load value from the architectural rules.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] base,
                                  input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd);
        logic [31:0] a;
        logic [31:0] v;
        logic [31:0] mask;
        int   n;
        int   sh;
        bit   ill;
        ev_t  e;
        mop_t m;
        a   = base + off;
        n   = nbytes(f3);
        ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        e.rd = 0;
        e.val = a;
        e.kind = K_EXC;
        if (ill) e.cause = 4'd2;
        else if (a % n != 0) e.cause = st ? 4'd6 : 4'd4;
        else if (a >= MEMN) e.cause = st ? 4'd7 : 4'd5;
        else e.cause = 4'd0;
        if (e.cause != 0) begin
            evq.push_back(e);
            return;
        end
        mask   = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        m.addr = a[AW-1:0];
        m.wd   = st ? wd & mask : 32'd0;
        if (st) m.op = n == 1 ? MEM_SB : n == 2 ? MEM_SH : MEM_SW;
        else    m.op = n == 1 ? MEM_LB : n == 2 ? MEM_LH : MEM_LW;
        memq.push_back(m);
        if (st) begin
            for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
            e.kind = K_STORE;
            e.val  = 0;
        end else begin
            v = 0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(a) + k];
            if (!f3[2] && n < 4) begin
                sh = 32 - 8 * n;
                v  = 32'($signed(v << sh) >>> sh);
            end
            e.kind = K_LOAD;
            e.val  = v;
            e.rd   = rd;
        end
        evq.push_back(e);
    endfunction

    // Entered and left just after a rising edge; accepted at the first edge where ex_ready is high.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd);
        int n;
        n = 0;
        bus.ex_valid  = 1'b1;
        bus.ex_store  = st;
        bus.ex_funct3 = f3;
        bus.ex_base   = base;
        bus.ex_offset = off;
        bus.ex_wdata  = wd;
        bus.ex_rd     = rd;
        @(negedge clk);
        while (!bus.ex_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ex_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ex_ready stuck at %b, required 1", bus.ex_ready);
        end else begin
            model(st, f3, base, off, wd, rd);
        end
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
    endtask

    task automatic load_expect(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        int n;
        n = 0;
        issue(1'b0, f3, a, 32'd0, 32'd0, 5'd1);
        @(negedge clk);
        while (!bus.wb_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("load_value", bus.wb_data, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic exc_expect(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [3:0] c);
        issue(st, f3, a, 32'd0, 32'h1234_5678, 5'd2);
        @(negedge clk);
        chk("exc_valid", {31'd0, bus.exc_valid}, 32'd1);
        chk("exc_cause", {28'd0, bus.exc_cause}, {28'd0, c});
        chk("exc_tval", bus.exc_tval, a);
        @(posedge clk);
        #1;
    endtask

    // Memory: writes at the sampling edge, read data appears the cycle after issue.
    initial begin
        logic [31:0] r;
        int n;
        for (int i = 0; i < MEMN; i++) mem[i] = 8'(i * 37 + 5);
        bus.rdata = 32'd0;
        forever begin
            @(posedge clk);
            if (!bus.stall) begin
                n = bus.op_code == MEM_SW ? 4 : 1 << bus.op_code[1:0];
                if (bus.op_code[2]) begin
                    for (int k = 0; k < n; k++) mem[(int'(bus.rwaddr) + k) % MEMN] = bus.wdata[8*k +: 8];
                end else begin
                    r = 0;
                    for (int k = 0; k < n; k++) r[8*k +: 8] = mem[(int'(bus.rwaddr) + k) % MEMN];
                    bus.rdata <= r;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) bus.wb_ready = $urandom_range(0, 3) != 0;
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        bit          held;
        logic [31:0] hd;
        logic [4:0]  hr;
        mop_t        m;
        ev_t         e;
        held = 0;
        hd = 0;
        hr = 0;
        forever begin
            @(negedge clk);
            if (nrst) begin
                held = 0;
                continue;
            end
            if (!bus.stall) begin
                if (memq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_issue: unexpected op %b addr %h, required no access", bus.op_code, bus.rwaddr);
                end else begin
                    m = memq.pop_front();
                    chk("op_code", {29'd0, bus.op_code}, {29'd0, m.op});
                    chk("rwaddr", {18'd0, bus.rwaddr}, {18'd0, m.addr});
                    if (m.op[2]) chk("wdata", bus.wdata, m.wd);
                end
            end
            if (held) begin
                chk("wb_hold_valid", {31'd0, bus.wb_valid}, 32'd1);
                chk("wb_hold_data", bus.wb_data, hd);
                chk("wb_hold_rd", {27'd0, bus.wb_rd}, {27'd0, hr});
            end
            held = bus.wb_valid && !bus.wb_ready;
            hd   = bus.wb_data;
            hr   = bus.wb_rd;
            if (bus.exc_valid || bus.store_done || (bus.wb_valid && bus.wb_ready)) begin
                if (evq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL event: unexpected exc=%b store=%b wb=%b, required none",
                             bus.exc_valid, bus.store_done, bus.wb_valid);
                end else begin
                    e = evq.pop_front();
                    if (bus.exc_valid) begin
                        chk("ev_kind_exc", K_EXC, e.kind);
                        chk("ev_cause", {28'd0, bus.exc_cause}, {28'd0, e.cause});
                        chk("ev_tval", bus.exc_tval, e.val);
                    end else if (bus.store_done) begin
                        chk("ev_kind_store", K_STORE, e.kind);
                    end else begin
                        chk("ev_kind_load", K_LOAD, e.kind);
                        chk("ev_wb_data", bus.wb_data, e.val);
                        chk("ev_wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0] ld_f3 [5];
        logic       st;
        logic [2:0] f3;
        logic [31:0] base;
        int n;
        ld_f3[0] = F3_LB; ld_f3[1] = F3_LH; ld_f3[2] = F3_LW; ld_f3[3] = F3_LBU; ld_f3[4] = F3_LHU;
        for (int i = 0; i < MEMN; i++) ref_mem[i] = 8'(i * 37 + 5);
        bus.ex_valid = 0; bus.ex_store = 0; bus.ex_funct3 = 0; bus.ex_base = 0;
        bus.ex_offset = 0; bus.ex_wdata = 0; bus.ex_rd = 0; bus.wb_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op_code", {29'd0, bus.op_code}, 32'd3);
        chk("rst_stall", {31'd0, bus.stall}, 32'd1);
        chk("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_store_done", {31'd0, bus.store_done}, 32'd0);
        chk("rst_exc_valid", {31'd0, bus.exc_valid}, 32'd0);
        chk("rst_rwaddr", {18'd0, bus.rwaddr}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        nrst = 0;

        issue(1'b1, F3_SW, 32'h7F0, 32'hC, 32'h1, 5'd0);
        issue(1'b0, F3_LW, 32'h7F0, 32'hC, 32'h0, 5'd5);
        @(negedge clk);
        chk("lw_lat_access", {31'd0, bus.wb_valid}, 32'd0);
        chk("lw_lat_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        chk("lw_lat_resp", {31'd0, bus.wb_valid}, 32'd0);
        @(negedge clk);
        chk("lw_lat_wb", {31'd0, bus.wb_valid}, 32'd1);
        chk("lw_data", bus.wb_data, 32'h1);
        @(posedge clk);
        #1;

        issue(1'b1, F3_SB, 32'h1BF8, 32'd0, 32'hAAAA_AA80, 5'd0);
        load_expect(F3_LB, 32'h1BF8, 32'hFFFF_FF80);
        load_expect(F3_LBU, 32'h1BF8, 32'h0000_0080);
        issue(1'b1, F3_SH, 32'h1BF8, 32'd0, 32'h5555_8001, 5'd0);
        load_expect(F3_LH, 32'h1BF8, 32'hFFFF_8001);
        load_expect(F3_LHU, 32'h1BF8, 32'h0000_8001);

        exc_expect(1'b0, F3_LW, 32'h1002, 4'd4);
        exc_expect(1'b1, F3_SH, 32'h4001, 4'd6);
        exc_expect(1'b1, F3_SW, 32'h4000, 4'd7);
        exc_expect(1'b0, 3'b011, 32'h100, 4'd2);
        exc_expect(1'b1, 3'b100, 32'h100, 4'd2);

        bus.wb_ready = 0;
        issue(1'b0, F3_LW, 32'h7FC, 32'd0, 32'd0, 5'd7);
        n = 0;
        @(negedge clk);
        while (!bus.wb_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        fork
            issue(1'b0, F3_LBU, 32'h1BF8, 32'd0, 32'd0, 5'd9);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_ex_ready", {31'd0, bus.ex_ready}, 32'd0);
                    chk("bp_data", bus.wb_data, 32'h1);
                    chk("bp_rd", {27'd0, bus.wb_rd}, 32'd7);
                end
                @(posedge clk);
                #1;
                bus.wb_ready = 1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        issue(1'b0, F3_LW, 32'h1BF8, 32'd0, 32'd0, 5'd3);
        @(posedge clk);
        #1;
        nrst = 1;
        evq.delete();
        @(posedge clk);
        #1;
        nrst = 0;
        chk("rst_mid_op_code", {29'd0, bus.op_code}, 32'd3);
        chk("rst_mid_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
            chk("rst_mid_stall", {31'd0, bus.stall}, 32'd1);
        end
        @(posedge clk);
        #1;

        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            case ($urandom_range(0, 9))
                0:       base = $urandom;
                1:       base = 32'(MEMN - 8 + $urandom_range(0, 12));
                2:       base = 32'($urandom_range(0, MEMN - 1));
                default: base = 32'($urandom_range(0, MEMN - 1)) & 32'hFFFF_FFFC;
            endcase
            issue(st, f3, base, 32'($signed($urandom_range(0, 8)) - 4) & 32'hFFFF_FFFC,
                  $urandom, 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_ready = 0;
        #3;
        bus.wb_ready = 1;
        n = 0;
        while (evq.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_events", evq.size(), 32'd0);
        chk("drain_mem", memq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store unit sitting directly upstream of the data `memory` block in the RISC-V core.
- Accepts one decoded load or store per transaction from EX, computes and checks the byte address, and drives the memory's `op_code`/`rwaddr`/`wdata`/`stall` port.
- For loads, captures `rdata`, sign- or zero-extends it, and hands the result to writeback with a valid/ready handshake.
- Raises precise exceptions for misaligned, out-of-range or illegal accesses without touching memory.

Parameters:
- AW, 14, memory byte-address width (16 KiB data memory).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  core clock, all state on rising edge.
- nrst  in  1  synchronous, active-high reset (1 = reset), sampled on clk rising edge.
- ex_valid  in  1  request present from EX.
- ex_ready  out  1  LSU can accept a request this cycle.
- ex_store  in  1  1 = store, 0 = load.
- ex_funct3  in  3  RISC-V funct3 of the load/store.
- ex_base  in  32  rs1 value.
- ex_offset  in  32  sign-extended immediate.
- ex_wdata  in  32  rs2 value (stores).
- ex_rd  in  5  destination register (loads).
- op_code  out  3  memory op, encoded as {write, size}.
- rwaddr  out  AW  memory byte address.
- wdata  out  32  store data, right-justified.
- stall  out  1  1 = memory idle/hold.
- rdata  in  32  memory read data, right-justified and zero-filled, valid one cycle after the load is issued.
- wb_valid, wb_ready  out/in  1  writeback handshake.
- wb_rd  out  5  writeback destination register.
- wb_data  out  32  extended load result.
- store_done  out  1  one-cycle pulse when a store has been issued.
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  4  mcause code.
- exc_tval  out  32  faulting address.

Behaviour:
- Memory op_code encoding:
  - Loads: 000 = byte, 001 = half, 010 = word.
  - Stores: 100 = byte, 101 = half, 111 = word.
  - 011 = NOP; 110 is never driven.
- Address: addr = ex_base + ex_offset, modulo 2^32.
- Checks are applied at accept, in this priority order:
  1. Illegal funct3 → cause 2. Illegal means load funct3 in {011, 110, 111}, or store funct3 not in {000, 001, 010}.
  2. Misaligned → cause 4 (load) / 6 (store). Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  3. Out of range → cause 5 (load) / 7 (store). Out of range means addr[31:AW]≠0.
- Reset values: FSM=IDLE, op_code=011, stall=1, rwaddr=0, wdata=0, wb_valid=0, wb_rd=0, wb_data=0, store_done=0, exc_valid=0, exc_cause=0, exc_tval=0.
- ex_ready = (state==IDLE) && !(wb_valid && !wb_ready).
- FSM state IDLE:
  - Outputs: op_code=011, stall=1.
  - On ex_valid && ex_ready with a check failure: register exc_valid=1, cause, tval=addr for exactly one cycle; stay in IDLE; no memory op issued.
  - On ex_valid && ex_ready with no failure: latch op, addr[AW-1:0] and rd. Store data is masked to size (byte: [7:0], half: [15:0], upper bits 0). Go to ACCESS.
- FSM state ACCESS (one cycle):
  - Drive op_code, rwaddr, wdata from the latches with stall=0; memory samples at the end of this cycle.
  - Store: store_done=1 next cycle; go to IDLE.
  - Load: go to RESP.
- FSM state RESP (one cycle):
  - stall=1, op_code=011.
  - Extend rdata: LB sign-extends bit 7, LH sign-extends bit 15, LBU/LHU zero-extend, LW passes through.
  - Register into wb_data, set wb_valid=1 and wb_rd; go to IDLE.
- Timing:
  - Load: accepted at edge E0; memory issue during E0–E1; wb_valid high from E2.
  - Store: store_done pulses in the cycle after ACCESS.
  - Throughput: one request per 2 (store) or 3 (load) cycles when wb_ready is held high.
- Writeback handshake: wb_valid, wb_data and wb_rd are held stable until wb_valid && wb_ready. The completing edge clears wb_valid unless a new result is written at the same edge.
- Back-to-back loads: a new request is not accepted while a result is held with wb_ready=0.
- rd=0 loads still complete normally; suppressing the x0 write is writeback's job.
- nrst asserted in any state: all registers return to reset values at that edge. In-flight results are discarded; no wb_valid, store_done or exc pulse follows.
- A store issued in the ACCESS cycle where reset is sampled is not reported.

Decomposition:
- Shared package `lsu_pkg`:
  - Memory op_code constants: MEM_LB, MEM_LH, MEM_LW, MEM_SB, MEM_SH, MEM_SW, MEM_NOP.
  - RISC-V funct3 constants.
  - mcause constants.
  - FSM state enum.
- One sub-module, `lsu_load_ext`: combinational funct3-driven extension of rdata.

Test Plan:
- Reset: nrst=1 for 2 cycles → op_code=011, stall=1, all valids 0, ex_ready=1.
- SW then LW: base=0x7F0, off=0xC, rs2=0x0000_0001 → op_code=111, rwaddr=0x07FC, wdata=1, store_done pulse; LW from the same address → op_code=010, wb_data=0x1, wb_valid at E0+2.
- LB vs LBU at 0x1BF8: rdata=0x0000_0080 → LB gives wb_data=0xFFFF_FF80, LBU gives 0x0000_0080. LH with rdata=0x0000_8001 → 0xFFFF_8001.
- Misaligned/range/illegal:
  - LW at 0x1002 → exc cause 4, tval 0x1002, no stall=0 cycle.
  - SH at 0x4001 → cause 6 (misaligned beats range).
  - SW at 0x4000 → cause 7.
  - Load funct3=011 → cause 2.
- Writeback backpressure: wb_ready=0 for 4 cycles after a load completes → wb_data stable, ex_ready=0, second request not accepted until the handshake completes.
- Reset mid-load: assert nrst during RESP → no wb_valid afterward; FSM in IDLE with op_code=011.
